// File: rtl/systolic_pkg.sv
// systolic_pkg: shared matrix geometry, element packing helper and drain states.
package systolic_pkg;
    localparam int MAT_ROWS  = 3;
    localparam int MAT_COLS  = 3;
    localparam int MAT_LEN   = MAT_ROWS * MAT_COLS;
    localparam int DATA_SIZE = 8;
    localparam int ACC_SIZE  = 16;

    // Element (0,0) sits in the MSBs of the flattened result vector.
    function automatic int elem_lsb(input int k);
        return (MAT_LEN - 1 - k) * ACC_SIZE;
    endfunction

    typedef enum logic {IDLE, STREAM} drain_state_t;
endpackage

// File: rtl/systolic_result_drain.sv
// systolic_result_drain: snapshots the array result on done rising and streams it row-major over valid/ready.
module systolic_result_drain
    import systolic_pkg::*;
#(
    parameter int MAT_ROWS = systolic_pkg::MAT_ROWS,
    parameter int MAT_COLS = systolic_pkg::MAT_COLS,
    parameter int MAT_LEN  = MAT_ROWS * MAT_COLS,
    parameter int ACC_SIZE = systolic_pkg::ACC_SIZE,
    parameter int IDX_W    = $clog2(MAT_LEN)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          arr_done,
    input  logic [MAT_LEN*ACC_SIZE-1:0]   arr_result,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [ACC_SIZE-1:0]           m_data,
    output logic [$clog2(MAT_ROWS)-1:0]   m_row,
    output logic [$clog2(MAT_COLS)-1:0]   m_col,
    output logic                          m_last,
    output logic                          busy,
    output logic                          overrun
);
    localparam int ROW_W = $clog2(MAT_ROWS);
    localparam int COL_W = $clog2(MAT_COLS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MAT_LEN - 1);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(MAT_COLS - 1);

    drain_state_t state, state_d;
    logic [ACC_SIZE-1:0] shadow [MAT_LEN];
    logic [IDX_W-1:0] idx;
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
    logic done_q, done_rise, is_last, xfer, last_xfer, capture;

    always_comb begin
        busy      = state == STREAM;
        m_valid   = busy;
        m_data    = busy ? shadow[idx] : '0;
        m_row     = row;
        m_col     = col;
        is_last   = idx == LAST_IDX;
        m_last    = busy && is_last;
        done_rise = arr_done && !done_q;
        xfer      = busy && m_ready;
        last_xfer = xfer && is_last;
        // A result landing on the final handshake chains straight into the next frame.
        capture   = done_rise && (!busy || last_xfer);
        state_d   = capture ? STREAM : last_xfer ? IDLE : state;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            done_q  <= 1'b1;
            overrun <= 1'b0;
            idx     <= '0;
            row     <= '0;
            col     <= '0;
            for (int k = 0; k < MAT_LEN; k++) shadow[k] <= '0;
        end else begin
            state  <= state_d;
            done_q <= arr_done;
            if (done_rise && busy && !last_xfer) overrun <= 1'b1;
            if (capture) begin
                idx <= '0;
                row <= '0;
                col <= '0;
                for (int k = 0; k < MAT_LEN; k++)
                    shadow[k] <= arr_result[(MAT_LEN-k)*ACC_SIZE-1 -: ACC_SIZE];
            end else if (last_xfer) begin
                idx <= '0;
                row <= '0;
                col <= '0;
            end else if (xfer) begin
                idx <= idx + 1'b1;
                col <= (col == LAST_COL) ? '0 : col + 1'b1;
                row <= (col == LAST_COL) ? row + 1'b1 : row;
            end
        end
    end
endmodule

// File: tb/tb_systolic_result_drain.sv
// tb_systolic_result_drain: scoreboard bench for the result drain; expectations queued at stimulus time.
module tb_systolic_result_drain;
    import systolic_pkg::*;

    typedef struct packed {
        logic [15:0] data;
        logic [1:0]  row;
        logic [1:0]  col;
        logic        last;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic arr_done = 1'b1;
    logic [MAT_LEN*ACC_SIZE-1:0] arr_result = '0;
    logic m_valid, m_ready = 1'b1;
    logic [15:0] m_data;
    logic [1:0] m_row, m_col;
    logic m_last, busy, overrun;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int mode = 0;
    exp_t sb[$];

    systolic_result_drain dut (
        .clk(clk), .reset(reset), .arr_done(arr_done), .arr_result(arr_result),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_row(m_row),
        .m_col(m_col), .m_last(m_last), .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    // Outputs and m_ready are stable at the falling edge; a valid&ready seen here transfers on the next rise.
    exp_t prev;
    logic prev_stall = 1'b0;
    always @(negedge clk) begin
        if (prev_stall && !reset) begin
            tests++;
            if (!m_valid || {m_data, m_row, m_col, m_last} !== prev) begin
                fails++;
                $display("FAIL stall_hold: got v=%0b %h r%0d c%0d l%0b want v=1 %h r%0d c%0d l%0b",
                         m_valid, m_data, m_row, m_col, m_last, prev.data, prev.row, prev.col, prev.last);
            end
        end
        prev = {m_data, m_row, m_col, m_last};
        prev_stall = m_valid && !m_ready && !reset;
        if (m_valid && m_ready && !reset) begin
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL unexpected_xfer: got %h r%0d c%0d want nothing", m_data, m_row, m_col);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if ({m_data, m_row, m_col, m_last} !== e) begin
                    fails++;
                    $display("FAIL xfer: got %h r%0d c%0d l%0b want %h r%0d c%0d l%0b",
                             m_data, m_row, m_col, m_last, e.data, e.row, e.col, e.last);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        m_ready = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 3 == 0) : 1'b0;
    endtask

    function automatic logic [MAT_LEN*ACC_SIZE-1:0] make_result(input int base, input bit flood);
        logic [MAT_LEN*ACC_SIZE-1:0] r;
        r = '0;
        for (int k = 0; k < MAT_LEN; k++)
            r[elem_lsb(k) +: ACC_SIZE] = flood ? 16'hFFFF : 16'(base + k);
        return r;
    endfunction

    task automatic push_frame(input int base);
        for (int k = 0; k < MAT_LEN; k++)
            sb.push_back({16'(base + k), 2'(k / MAT_COLS), 2'(k % MAT_COLS), k == MAT_LEN - 1});
    endtask

    task automatic launch(input int base);
        push_frame(base);
        arr_done = 1'b0;
        tick();
        arr_done = 1'b1;
        arr_result = make_result(base, 1'b0);
        tests++;
        if (m_valid !== 1'b0) begin
            fails++;
            $display("FAIL early_valid: got %0b want 0", m_valid);
        end
        tick();
        tests++;
        if (m_valid !== 1'b1) begin
            fails++;
            $display("FAIL latency_valid: got %0b want 1", m_valid);
        end
    endtask

    task automatic wait_empty(input string name);
        int n = 0;
        while ((sb.size() != 0 || m_valid) && n < 200) begin
            tick();
            n++;
        end
        tests++;
        if (n >= 200) begin
            fails++;
            $display("FAIL %s_timeout: got %0d left want 0", name, sb.size());
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        tests++;
        if ({m_valid, m_data, m_row, m_col, m_last, busy, overrun} !== '0) begin
            fails++;
            $display("FAIL reset_vals: got v%0b d%h r%0d c%0d l%0b b%0b o%0b want all 0",
                     m_valid, m_data, m_row, m_col, m_last, busy, overrun);
        end
        reset = 1'b0;
    endtask

    task automatic test_idle();
        for (int i = 0; i < 20; i++) begin
            tick();
            tests++;
            if (m_valid !== 1'b0 || overrun !== 1'b0) begin
                fails++;
                $display("FAIL idle: got v%0b o%0b want v0 o0", m_valid, overrun);
            end
        end
    endtask

    task automatic test_basic();
        mode = 0;
        launch(1);
        wait_empty("basic");
    endtask

    task automatic test_stall();
        mode = 1;
        launch(1);
        wait_empty("stall");
        mode = 0;
    endtask

    task automatic test_back_to_back();
        mode = 0;
        launch(1);
        for (int i = 0; i < 7; i++) tick();
        arr_done = 1'b0;
        tick();
        push_frame(10);
        arr_done = 1'b1;
        arr_result = make_result(10, 1'b0);
        tick();
        tests++;
        if (m_valid !== 1'b1 || m_data !== 16'd10 || overrun !== 1'b0) begin
            fails++;
            $display("FAIL b2b_chain: got v%0b d%0d o%0b want v1 d10 o0", m_valid, m_data, overrun);
        end
        wait_empty("b2b");
        tests++;
        if (overrun !== 1'b0) begin
            fails++;
            $display("FAIL b2b_overrun: got %0b want 0", overrun);
        end
    endtask

    task automatic test_overrun();
        mode = 0;
        launch(1);
        for (int i = 0; i < 3; i++) tick();
        arr_done = 1'b0;
        tick();
        arr_done = 1'b1;
        arr_result = make_result(0, 1'b1);
        tick();
        tests++;
        if (overrun !== 1'b1) begin
            fails++;
            $display("FAIL overrun_set: got %0b want 1", overrun);
        end
        wait_empty("overrun");
        for (int i = 0; i < 5; i++) tick();
        tests++;
        if (overrun !== 1'b1 || m_valid !== 1'b0) begin
            fails++;
            $display("FAIL overrun_sticky: got o%0b v%0b want o1 v0", overrun, m_valid);
        end
    endtask

    task automatic test_reset_mid();
        mode = 0;
        launch(1);
        for (int i = 0; i < 4; i++) tick();
        mode = 2;
        m_ready = 1'b0;
        reset = 1'b1;
        tick();
        sb.delete();
        tests++;
        if (m_valid !== 1'b0 || busy !== 1'b0 || m_data !== 16'd0 || overrun !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid: got v%0b b%0b d%h o%0b want v0 b0 d0 o0", m_valid, busy, m_data, overrun);
        end
        reset = 1'b0;
        mode = 0;
        tick();
        tick();
        launch(21);
        tests++;
        if (m_data !== 16'd21 || m_row !== 2'd0 || m_col !== 2'd0) begin
            fails++;
            $display("FAIL restart: got d%0d r%0d c%0d want d21 r0 c0", m_data, m_row, m_col);
        end
        wait_empty("restart");
    endtask

    initial begin
        test_reset();
        test_idle();
        test_basic();
        test_stall();
        test_back_to_back();
        test_overrun();
        test_reset_mid();
        tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/systolic_result_drain.md
# systolic_result_drain

Drains the 3x3 systolic array after each computation. On the rising edge of the array's `done`, it snapshots the flattened accumulator result vector. It then streams the nine 16-bit elements out one at a time, in row-major order, over a valid/ready handshake. The block sits between the array's `result`/`done` outputs and the downstream consumer: result memory, bus bridge or testbench scoreboard.

## Interface
Parameters:
- `MAT_ROWS`, default 3: rows of the result matrix.
- `MAT_COLS`, default 3: columns of the result matrix.
- `MAT_LEN`, default `MAT_ROWS*MAT_COLS`: element count.
- `ACC_SIZE`, default 16: accumulator/element width.
- `IDX_W`, default `$clog2(MAT_LEN)`: element index width.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-high.
- `arr_done`  in  1  array `done` level. The array holds it high at reset and while idle; it goes low while computing and returns high when results are final.
- `arr_result`  in  `MAT_LEN*ACC_SIZE`  flattened array result. Element k = r*MAT_COLS+c occupies bits `[(MAT_LEN-k)*ACC_SIZE-1 -: ACC_SIZE]`, so element (0,0) is in the MSBs.
- `m_valid`  out  1  output element valid.
- `m_ready`  in  1  consumer ready.
- `m_data`  out  `ACC_SIZE`  current element.
- `m_row`  out  `$clog2(MAT_ROWS)`  row of current element.
- `m_col`  out  `$clog2(MAT_COLS)`  column of current element.
- `m_last`  out  1  high with the element (MAT_ROWS-1, MAT_COLS-1).
- `busy`  out  1  snapshot held, stream in progress.
- `overrun`  out  1  sticky error: a new result arrived mid-stream.

## Operation
- `done_q` registers `arr_done`. Its reset value is 1, so the post-reset high level of `arr_done` is not treated as a new result.
- `done_rise` = `arr_done & ~done_q`.
- The shadow register holds `MAT_LEN` x `ACC_SIZE` elements. It is written only on an accepted capture.
- State IDLE:
  - `m_valid`=0, `busy`=0.
  - On `done_rise`: load shadow from `arr_result`, set idx=0, row=0, col=0, go to STREAM.
- State STREAM:
  - `m_valid`=1, `busy`=1, `m_data`=shadow[idx], `m_last`=(idx==MAT_LEN-1).
  - On `m_valid & m_ready` with idx<MAT_LEN-1: idx increments. col increments; when col wraps from MAT_COLS-1 to 0, row increments.
  - On `m_valid & m_ready` with idx==MAT_LEN-1: return to IDLE.
- Handshake rules:
  - While `m_valid`=1 and `m_ready`=0, `m_data`, `m_row`, `m_col` and `m_last` hold stable.
  - `m_valid` never drops without a transfer.
- Overrun: `done_rise` in STREAM without a final-element handshake in the same cycle sets `overrun`=1. The new result is discarded, and the current stream continues unchanged. `overrun` clears only on reset.
- Simultaneous events: `done_rise` in the same cycle as the final handshake is accepted, not an overrun. The shadow reloads, idx=0, and the state stays STREAM, giving back-to-back frames with no bubble.
- `m_row` and `m_col` are counters, not a divide of idx.
- Data passes through unmodified: no sign handling, no truncation.

## Timing
- Reset values:
  - `m_valid`=0, `m_data`=0, `m_row`=0, `m_col`=0, `m_last`=0, `busy`=0, `overrun`=0.
  - State IDLE, idx=0, shadow=0, `done_q`=1.
- Reset mid-stream aborts the frame. Outputs return to reset values on the next edge, and there is no residual valid.
- Latency: `arr_done` is sampled high (previously low) at edge N, so `m_valid`=1 and element (0,0) appear after edge N.
- Throughput: one element per cycle with `m_ready` held high. A frame takes MAT_LEN=9 cycles from first valid to the last transfer.
- All outputs are registered or a mux of registered state. There is no combinational path from `arr_result`, `arr_done` or `m_ready` to any output.

## Structure
- Shared package `systolic_pkg` holds:
  - `MAT_ROWS`, `MAT_COLS`, `MAT_LEN`, `DATA_SIZE`, `ACC_SIZE`.
  - A function `elem_lsb(k)` returning `(MAT_LEN-1-k)*ACC_SIZE`, reused by the array, loaders and this block.
  - The state enum {IDLE, STREAM}.
- No sub-module: a single FSM plus a shadow register array and idx/row/col counters.

## Test plan
- Reset, then hold `arr_done`=1 for 20 cycles: `m_valid` stays 0 and `overrun` stays 0.
- Pulse `arr_done` 1→0→1 with the result matrix = 1..9 (element (0,0)=1) and `m_ready`=1: nine consecutive transfers with `m_data`=1..9, (row,col) = (0,0)..(2,2), `m_last` only on the 9th (value 9), and `m_valid` first high one edge after `arr_done` rises.
- Same frame with `m_ready` toggling 1,0,0,1,…: exactly 9 transfers in order 1..9, outputs stable during stalls, no duplicates.
- Raise a second `done_rise` (result 0xFFFF in every element) after transfer 3 of frame 1: frame 1 completes as 1..9, `overrun`=1, and the 0xFFFF frame never appears.
- Time the second `done_rise` (results 10..18) exactly on the final handshake of frame 1: `m_valid` stays high, 10..18 follow immediately, `overrun`=0.
- Assert `reset` after transfer 4: next cycle `m_valid`=0, `busy`=0; a later fresh `done_rise` streams from element (0,0).
